// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle CPU sequencer:
// state encoding, stage strobe indices, default PC width.
package cpu_pkg;

  localparam int DEFAULT_PC_WIDTH = 8;

  localparam int NUM_STAGES = 5;
  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for write-back: jump over branch over increment.
// All arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc + PC_WIDTH'(1);

  always_comb begin
    pc_next = pc_inc;
    if (jump)
      pc_next = jump_target;
    else if (branch_taken)
      pc_next = pc_inc + branch_offset;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// PC owner and IF/ID/EX/MEM/WB stage generator for the multi-cycle CPU.
// Optional MEM watchdog: MULTICYCLE_SEQUENCER_MEM_TIMEOUT_EN.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int                   PC_WIDTH       = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC       = '0,
  parameter int                   COUNT_WIDTH    = 16,
  parameter int                   TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   mem_ready,
  input  logic                   skip_mem,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  output logic                   if_stage,
  output logic                   id_stage,
  output logic                   ex_stage,
  output logic                   mem_stage,
  output logic                   wb_stage,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   running,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state_q;
  state_t                  state_d;
  logic [NUM_STAGES-1:0]   stage_q;
  logic [NUM_STAGES-1:0]   stage_d;
  logic                    running_q;
  logic                    halted_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [PC_WIDTH-1:0]     pc_nxt;
  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic                    tmo_hit;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_next       (pc_nxt)
  );

`ifdef MULTICYCLE_SEQUENCER_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              tmo_q;

  // fires on the cycle whose stall brings the count to the limit
  assign tmo_hit = (state_q == S_MEM) && !mem_ready &&
                   (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q != S_MEM)
        wait_q <= '0;
      else if (!mem_ready)
        wait_q <= wait_q + WAIT_W'(1);
      if (tmo_hit)
        tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_HALT: if (start) state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID:   state_d = S_EX;
      S_EX:   state_d = skip_mem ? S_WB : S_MEM;
      S_MEM: begin
        if (mem_ready)
          state_d = S_WB;
        else if (tmo_hit)
          state_d = S_HALT;
      end
      S_WB:   state_d = halt ? S_HALT : S_IF;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stage_d = '0;
    unique case (state_d)
      S_IF:    stage_d[STG_IF]  = 1'b1;
      S_ID:    stage_d[STG_ID]  = 1'b1;
      S_EX:    stage_d[STG_EX]  = 1'b1;
      S_MEM:   stage_d[STG_MEM] = 1'b1;
      S_WB:    stage_d[STG_WB]  = 1'b1;
      default: stage_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      running_q <= |stage_d;
      halted_q  <= (state_d == S_HALT);
      if (state_q == S_WB) begin
        pc_q  <= pc_nxt;
        cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign if_stage    = stage_q[STG_IF];
  assign id_stage    = stage_q[STG_ID];
  assign ex_stage    = stage_q[STG_EX];
  assign mem_stage   = stage_q[STG_MEM];
  assign wb_stage    = stage_q[STG_WB];
  assign pc          = pc_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed plus randomized bench for multicycle_sequencer.
// Reference model tracks pc / retired count arithmetically per instruction.
module tb_multicycle_sequencer;

  localparam int PW = 8;
  localparam int CW = 4;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          mem_ready = 1'b0;
  logic          skip_mem = 1'b0;
  logic          jump = 1'b0;
  logic [PW-1:0] jump_target = '0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_offset = '0;
  logic          if_stage, id_stage, ex_stage, mem_stage, wb_stage;
  logic [PW-1:0] pc;
  logic          running, halted, timeout_err;
  logic [CW-1:0] instr_count;
  logic [4:0]    stg;

  int            tests = 0;
  int            fails = 0;
  logic [PW-1:0] m_pc;
  int            m_cnt;

  multicycle_sequencer #(
    .PC_WIDTH       (PW),
    .RESET_PC       (8'hFF),
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .halt          (halt),
    .mem_ready     (mem_ready),
    .skip_mem      (skip_mem),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .if_stage      (if_stage),
    .id_stage      (id_stage),
    .ex_stage      (ex_stage),
    .mem_stage     (mem_stage),
    .wb_stage      (wb_stage),
    .pc            (pc),
    .running       (running),
    .halted        (halted),
    .instr_count   (instr_count),
    .timeout_err   (timeout_err)
  );

  assign stg = {wb_stage, mem_stage, ex_stage, id_stage, if_stage};

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // noise on every control input; stage-relevant ones are overridden after
  task automatic junk();
    start         = 1'($urandom_range(1));
    halt          = 1'($urandom_range(1));
    mem_ready     = 1'($urandom_range(1));
    skip_mem      = 1'($urandom_range(1));
    jump          = 1'($urandom_range(1));
    branch_taken  = 1'($urandom_range(1));
    jump_target   = PW'($urandom);
    branch_offset = PW'($urandom);
  endtask

  task automatic check_state(string tag, logic [4:0] exp_stg);
    chk({tag, "_stage"}, 32'(stg), 32'(exp_stg));
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_count"}, 32'(instr_count), 32'(m_cnt % (1 << CW)));
    chk({tag, "_running"}, 32'(running), 32'(|exp_stg));
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // expects the DUT in IF at entry; leaves it in IF or HALT
  task automatic do_instr(int waits, bit sk, bit j, logic [PW-1:0] jt,
                          bit b, logic [PW-1:0] off, bit h);
    junk();
    check_state("if", 5'b00001);
    step();
    junk();
    check_state("id", 5'b00010);
    step();
    junk();
    skip_mem = sk;
    check_state("ex", 5'b00100);
    step();
    if (!sk) begin
      for (int k = 0; k <= waits; k++) begin
        junk();
        mem_ready = (k == waits);
        check_state("mem", 5'b01000);
        step();
      end
    end
    junk();
    start         = 1'b0;
    halt          = h;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_offset = off;
    check_state("wb", 5'b10000);
    step();
    if (j)
      m_pc = jt;
    else if (b)
      m_pc = m_pc + 8'd1 + off;
    else
      m_pc = m_pc + 8'd1;
    m_cnt++;
    start = 1'b0;
    if (h) begin
      check_state("halt", 5'b00000);
      chk("halt_flag", 32'(halted), 32'd1);
    end else begin
      chk("run_halted", 32'(halted), 32'd0);
    end
  endtask

  initial begin
    m_pc  = 8'hFF;
    m_cnt = 0;
    #12;
    check_state("reset", 5'b00000);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_tmo", 32'(timeout_err), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_state("idle", 5'b00000);
    restart();

    do_instr(0, 0, 0, 8'h00, 0, 8'h00, 0);
    do_instr(3, 0, 0, 8'h00, 0, 8'h00, 0);
    do_instr(0, 1, 0, 8'h00, 0, 8'h00, 0);
    do_instr(0, 1, 1, 8'h10, 0, 8'h00, 0);
    do_instr(0, 0, 0, 8'h00, 1, 8'hFC, 0);
    chk("branch_back", 32'(pc), 32'h0D);
    do_instr(1, 0, 1, 8'h40, 1, 8'h33, 0);
    chk("jump_wins", 32'(pc), 32'h40);
    do_instr(0, 1, 1, 8'h05, 0, 8'h00, 0);
    do_instr(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("halt_pc", 32'(pc), 32'h06);
    repeat (3) begin
      junk();
      start = 1'b0;
      step();
      check_state("hold", 5'b00000);
      chk("hold_halted", 32'(halted), 32'd1);
    end
    restart();
    chk("resume_pc", 32'(pc), 32'h06);

    for (int n = 0; n < 24; n++) begin
      automatic bit h = ($urandom_range(5) == 0);
      do_instr($urandom_range(3), 1'($urandom_range(1)),
               ($urandom_range(3) == 0), PW'($urandom),
               ($urandom_range(2) == 0), PW'($urandom), h);
      if (h) restart();
    end

    junk();
    step();
    junk();
    step();
    junk();
    skip_mem = 1'b0;
    step();
    junk();
    mem_ready = 1'b0;
    check_state("pre_rst_mem", 5'b01000);
    step();
    reset_n = 1'b0;
    #1;
    m_pc  = 8'hFF;
    m_cnt = 0;
    check_state("async_rst", 5'b00000);
    step();
    reset_n = 1'b1;
    start   = 1'b0;
    step();
    check_state("post_rst", 5'b00000);

    restart();
    junk();
    step();
    junk();
    step();
    junk();
    skip_mem = 1'b0;
    step();
    for (int k = 0; k < TO; k++) begin
      junk();
      mem_ready = 1'b0;
      if (k == 0 || k == TO - 1) check_state("wait", 5'b01000);
      step();
    end
`ifdef MULTICYCLE_SEQUENCER_MEM_TIMEOUT_EN
    start = 1'b0;
    check_state("timeout", 5'b00000);
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    restart();
    do_instr(0, 1, 0, 8'h00, 0, 8'h00, 0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
`else
    check_state("no_timeout", 5'b01000);
    chk("no_timeout_err", 32'(timeout_err), 32'd0);
    junk();
    mem_ready = 1'b1;
    step();
    junk();
    start        = 1'b0;
    halt         = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    check_state("late_wb", 5'b10000);
    step();
    m_pc = m_pc + 8'd1;
    m_cnt++;
    check_state("late_if", 5'b00001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
